// File: rtl/lfsr_if.sv
// lfsr_if: control and status bundle between an LFSR consumer and lfsr_gen
interface lfsr_if #(parameter int WIDTH = 8);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] out;
  logic             bit_out;
  logic             wrap;
  logic             seed_err;
  modport master (output en, load, seed_in, input out, bit_out, wrap, seed_err);
  modport slave  (input en, load, seed_in, output out, bit_out, wrap, seed_err);
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with seed load, zero-seed guard and wrap flag
module lfsr_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h71,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter bit               MODE  = 1'b0
) (
  input logic   clk,
  input logic   rst,
  lfsr_if.slave bus
);
  if (WIDTH < 3 || WIDTH > 32 || SEED == '0) begin : g_bad_cfg
    $fatal(1, "lfsr_gen: WIDTH must be 3..32 and SEED non-zero");
  end
  logic [WIDTH-1:0] state_q, state_d, start_q, start_d, cnt_q, cnt_d, mask, step;
  logic             wrap_q, wrap_d, seed_err_q, seed_err_d;
  // Fibonacci tap mask is the polynomial bit-reversed so out[WIDTH-1] pairs with x^0
  always_comb begin
    mask = '0;
    for (int j = 0; j < WIDTH; j++) mask[j] = POLY[WIDTH-1-j];
  end
  assign step = MODE ? ({state_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_q[WIDTH-1]}} & POLY))
                     : {state_q[WIDTH-2:0], ^(state_q & mask)};
  // Next state: load beats en; a zero seed falls back to SEED so lockup is unreachable
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    seed_err_d = 1'b0;
    if (bus.load) begin
      seed_err_d = (bus.seed_in == '0);
      state_d    = seed_err_d ? SEED : bus.seed_in;
      start_d    = state_d;
      cnt_d      = '0;
    end else if (bus.en) begin
      state_d = step;
      wrap_d  = (step == start_q);
      cnt_d   = wrap_d ? '0 : cnt_q + WIDTH'(1);
    end
  end
  // State registers with asynchronous active-low reset back to SEED
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEED;
      start_q    <= SEED;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      seed_err_q <= seed_err_d;
    end
  end
  assign bus.out      = state_q;
  assign bus.bit_out  = state_q[WIDTH-1];
  assign bus.wrap     = wrap_q;
  assign bus.seed_err = seed_err_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed checks of Fibonacci, Galois and 16-bit LFSR instances
module tb_lfsr_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed = 8'h00;
  int         checks = 0;
  int         errors = 0;
  lfsr_if #(8)  bf ();
  lfsr_if #(8)  bg ();
  lfsr_if #(16) bw ();
  assign bf.en = en;
  assign bf.load = load;
  assign bf.seed_in = seed;
  assign bg.en = en;
  assign bg.load = load;
  assign bg.seed_in = seed;
  assign bw.en = en;
  assign bw.load = load;
  assign bw.seed_in = {8'h00, seed};
  lfsr_gen #(.WIDTH(8), .POLY(8'h71), .SEED(8'h01), .MODE(1'b0)) u_fib (.clk(clk), .rst(rst), .bus(bf));
  lfsr_gen #(.WIDTH(8), .POLY(8'h71), .SEED(8'h01), .MODE(1'b1)) u_gal (.clk(clk), .rst(rst), .bus(bg));
  lfsr_gen #(.WIDTH(16), .POLY(16'h002D), .SEED(16'h0001), .MODE(1'b0)) u_w16 (.clk(clk), .rst(rst), .bus(bw));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit seen [256];
    int rep = 0, f8 = 0, g8 = 0, f16 = 0;
    repeat (3) tick();
    chk("rst_out", bf.out, 8'h01);
    chk("rst_wrap", bf.wrap, 0);
    chk("rst_serr", bf.seed_err, 0);
    chk("rst_out16", bw.out, 16'h0001);
    rst = 1'b1;
    repeat (2) tick();
    chk("idle_out", bf.out, 8'h01);
    chk("idle_bit", bf.bit_out, 0);
    en = 1'b1;
    seen[1] = 1'b1;
    for (int s = 1; s <= 65535; s++) begin
      tick();
      if (s == 1) chk("fib_s1", bf.out, 8'h02);
      if (s == 2) chk("fib_s2", bf.out, 8'h05);
      if (s == 3) chk("fib_s3", bf.out, 8'h0B);
      if (s <= 8) chk("gal_seq", bg.out, s < 8 ? (32'd1 << s) : 32'h71);
      if (s == 7) chk("gal_bit", bg.bit_out, 1);
      if (s < 255) begin
        if (seen[bf.out]) rep++;
        seen[bf.out] = 1'b1;
      end
      if (bf.wrap && f8 == 0) f8 = s;
      if (bg.wrap && g8 == 0) g8 = s;
      if (bw.wrap && f16 == 0) f16 = s;
      if (s == 255) begin
        chk("fib_wrap_out", bf.out, 8'h01);
        chk("gal_wrap_out", bg.out, 8'h01);
      end
      if (s == 256) chk("fib_wrap_pulse", bf.wrap, 0);
      if (s == 65535) chk("w16_wrap", bw.wrap, 1);
    end
    chk("fib_first_wrap", f8, 255);
    chk("gal_first_wrap", g8, 255);
    chk("fib_repeats", rep, 0);
    chk("w16_first_wrap", f16, 65535);
    chk("w16_wrap_out", bw.out, 16'h0001);
    en = 1'b0;
    load = 1'b1;
    seed = 8'h5A;
    tick();
    chk("load_5a", bf.out, 8'h5A);
    chk("load_serr", bf.seed_err, 0);
    seed = 8'h00;
    tick();
    chk("zero_out", bf.out, 8'h01);
    chk("zero_serr", bf.seed_err, 1);
    chk("zero_wrap", bf.wrap, 0);
    load = 1'b0;
    tick();
    chk("serr_pulse", bf.seed_err, 0);
    chk("hold_out", bf.out, 8'h01);
    load = 1'b1;
    en = 1'b1;
    seed = 8'h33;
    tick();
    chk("load_en_fib", bf.out, 8'h33);
    chk("load_en_gal", bg.out, 8'h33);
    chk("load_en_wrap", bf.wrap, 0);
    load = 1'b0;
    f8 = 0;
    g8 = 0;
    for (int s = 1; s <= 255; s++) begin
      tick();
      if (s == 1) chk("fib_33_s1", bf.out, 8'h67);
      if (bf.wrap && f8 == 0) f8 = s;
      if (bg.wrap && g8 == 0) g8 = s;
    end
    chk("fib33_wrap_step", f8, 255);
    chk("gal33_wrap_step", g8, 255);
    chk("fib33_wrap_out", bf.out, 8'h33);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("gate_out", bf.out, 8'h33);
    end
    chk("gate_wrap", bf.wrap, 0);
    en = 1'b1;
    tick();
    chk("resume", bf.out, 8'h67);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_fib", bf.out, 8'h01);
    chk("async_rst_w16", bw.out, 16'h0001);
    tick();
    chk("rst_held", bf.out, 8'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
